// File: rtl/stack_pkg.sv
// Shared definitions for the stack/queue control blocks: op encoding and
// the occupancy-counter width helper.
package stack_pkg;

    // Decoded request per cycle, formed as {PUSH, POP}
    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_PUSH    = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    // Ceiling log2; returns 0 for values <= 1
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width able to hold every occupancy from 0 to depth inclusive
    function automatic int count_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_status.sv
// Registered occupancy status: full/empty, programmable almost thresholds and
// a high-water mark.  Driven from the next-state count so every flag lines up
// with the registered count in the same cycle.
module stack_status
    import stack_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int CW = count_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic [CW-1:0] cnt_d_i,
    input  logic [CW-1:0] af_thresh_i,
    input  logic [CW-1:0] ae_thresh_i,
    output logic          full_o,
    output logic          empty_o,
    output logic          almost_full_o,
    output logic          almost_empty_o,
    output logic [CW-1:0] hwm_o
);

    logic          full_q, empty_q, af_q, ae_q;
    logic          full_d, empty_d, af_d, ae_d;
    logic [CW-1:0] hwm_q, hwm_d;

    // Next-state flags from the next count; clear forces the peak back to zero
    always_comb begin
        full_d  = (cnt_d_i == CW'(DEPTH));
        empty_d = (cnt_d_i == '0);
        af_d    = (cnt_d_i >= af_thresh_i);
        ae_d    = (cnt_d_i <= ae_thresh_i);
        hwm_d   = hwm_q;
        if (clr_i) begin
            hwm_d = '0;
        end else if (cnt_d_i > hwm_q) begin
            hwm_d = cnt_d_i;
        end
    end

    // Status registers; reset state describes an empty stack
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            hwm_q   <= '0;
        end else begin
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            hwm_q   <= hwm_d;
        end
    end

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign hwm_o          = hwm_q;

endmodule

// File: rtl/stack_ctrl.sv
// Control-path LIFO with a registered show-ahead top, replace-top on
// simultaneous push+pop, occupancy/peak tracking, almost thresholds, sticky
// overflow/underflow flags and a synchronous clear.
//
// The current top lives in top_q; entries below it live in mem[0..DEPTH-2],
// with mem[i] holding entry i.  A push spills the old top into mem[count-1];
// a pop reloads the top from mem[count-2].
//
// Handshake: there is no backpressure.  The consumer reads TOP while it is
// stable, then raises POP for one cycle; TOP shows the next entry after that
// edge.  Requests that cannot be honoured are dropped and flagged sticky.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1,
    localparam int CW = count_width(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CLR,
    input  logic                  CLR_ERR,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] TOP,
    output logic [CW-1:0]         COUNT,
    output logic [CW-1:0]         HWM,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int MEM_N = DEPTH - 1;
    localparam int AW    = (clog2(MEM_N) < 1) ? 1 : clog2(MEM_N);

    logic [DATA_WIDTH-1:0] mem [0:MEM_N-1];

    logic [DATA_WIDTH-1:0] top_q, top_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic [1:0]            op;
    logic                  is_empty, is_full;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [AW-1:0]         mem_raddr;

    assign op        = {PUSH, POP};
    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == CW'(DEPTH));
    assign mem_waddr = AW'(count_q - CW'(1));
    assign mem_raddr = AW'(count_q - CW'(2));

    // Op decode and next-state for count, top and error flags
    always_comb begin
        count_d = count_q;
        top_d   = top_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        mem_we  = 1'b0;

        if (CLR_ERR) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        if (CLR) begin
            count_d = '0;
            top_d   = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            case (op)
                OP_REPLACE: begin
                    top_d = DATA_IN;
                    if (is_empty) begin
                        // Nothing to replace: the push lands, the pop is an error
                        count_d = CW'(1);
                        udf_d   = 1'b1;
                    end
                end
                OP_PUSH: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we  = !is_empty;
                        top_d   = DATA_IN;
                        count_d = count_q + CW'(1);
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        udf_d = 1'b1;
                    end else begin
                        top_d   = (count_q >= CW'(2)) ? mem[mem_raddr] : '0;
                        count_d = count_q - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Storage below the top; contents are don't-care until written
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= top_q;
        end
    end

    // Top, occupancy and sticky error registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    stack_status #(
        .DEPTH (DEPTH)
    ) u_status (
        .clk_i          (CLK),
        .rst_ni         (RST_N),
        .clr_i          (CLR),
        .cnt_d_i        (count_d),
        .af_thresh_i    (CW'(AF_THRESH)),
        .ae_thresh_i    (CW'(AE_THRESH)),
        .full_o         (FULL),
        .empty_o        (EMPTY),
        .almost_full_o  (ALMOST_FULL),
        .almost_empty_o (ALMOST_EMPTY),
        .hwm_o          (HWM)
    );

    assign TOP       = top_q;
    assign COUNT     = count_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = udf_q;

endmodule
